// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: opcode/funct constants, ULAControl encodings and FSM states
package multicycle_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_NOR = 3'b011;
  localparam logic [2:0] ULA_SLL = 3'b100;
  localparam logic [2:0] ULA_SRL = 3'b101;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_SLT = 3'b111;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
  } state_e;
endpackage

// File: rtl/multicycle_ctrl_ula_decoder.sv
// ula_decoder: maps opcode/funct to ULAControl and flags decodable instructions
module ula_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] ula_control_o,
  output logic       legal_o
);
  logic [2:0] fn_ctl;
  logic       fn_ok;
  always_comb begin
    fn_ctl = ULA_ADD;
    fn_ok  = 1'b1;
    case (funct_i)
      FN_ADD:  fn_ctl = ULA_ADD;
      FN_SUB:  fn_ctl = ULA_SUB;
      FN_AND:  fn_ctl = ULA_AND;
      FN_OR:   fn_ctl = ULA_OR;
      FN_NOR:  fn_ctl = ULA_NOR;
      FN_SLT:  fn_ctl = ULA_SLT;
      FN_SLL:  fn_ctl = ULA_SLL;
      FN_SRL:  fn_ctl = ULA_SRL;
      default: fn_ok  = 1'b0;
    endcase
    ula_control_o = (opcode_i == OP_RTYPE) ? fn_ctl : (opcode_i == OP_BEQ) ? ULA_SUB : ULA_ADD;
    legal_o = (opcode_i == OP_RTYPE) ? fn_ok : (opcode_i inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle FSM sequencing fetch/decode/execute/memory/writeback
// with a bounded memory handshake that halts on timeout.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       z,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] ula_control,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_instr,
  output logic       bus_error
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_error_q, bus_error_d;
  logic [2:0]       dec_ctl;
  logic             dec_legal;
  logic             waiting, timeout;

  ula_decoder u_dec (
    .opcode_i      (opcode),
    .funct_i       (funct),
    .ula_control_o (dec_ctl),
    .legal_o       (dec_legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  // A ready arriving on the WAIT_MAX cycle wins over the timeout.
  assign waiting = (state_q inside {S_FETCH, S_MEMRD, S_MEMWR}) && !mem_ready;
  assign timeout = waiting && (wait_cnt_q == CNT_W'(WAIT_MAX));
  assign bus_error = bus_error_q;

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ula_control   = ULA_AND;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = 2'b01;
        ula_control = ULA_ADD;
        ir_write    = mem_ready;
        pc_en       = mem_ready;
        state_d     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b     = 2'b10;
        ula_control   = ULA_ADD;
        illegal_instr = !dec_legal;
        state_d = !dec_legal ? S_FETCH :
                  (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                  (opcode == OP_RTYPE) ? S_EXEC :
                  (opcode == OP_BEQ) ? S_BRANCH :
                  (opcode == OP_ADDI) ? S_ADDIEX : S_JUMP;
      end
      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        ula_control = ULA_ADD;
        state_d     = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        ula_control = dec_ctl;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        ula_control = ULA_SUB;
        pc_src      = 2'b01;
        pc_en       = z;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        ula_control = ULA_ADD;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_HALT;
    wait_cnt_d  = (state_d != state_q) ? '0 : waiting ? wait_cnt_q + 1'b1 : wait_cnt_q;
    bus_error_d = bus_error_q | timeout;
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized instruction streams checked against
// per-instruction expected control sequences derived from the ISA behaviour.
module tb_multicycle_ctrl;
  typedef struct packed {
    logic       mem_req, mem_write, i_or_d, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] ula_control;
    logic       reg_write, reg_dst, mem_to_reg, illegal_instr, bus_error;
  } outs_t;

  logic clk = 1'b0;
  logic rst, z, mem_ready;
  logic [5:0] opcode, funct;
  logic mem_req, mem_write, i_or_d, ir_write, pc_en, alu_src_a;
  logic reg_write, reg_dst, mem_to_reg, illegal_instr, bus_error;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] ula_control;
  int total = 0;
  int bad = 0;
  logic [5:0] fn_tab [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b100111, 6'b101010, 6'b000000, 6'b000010};
  logic [2:0] ulc_tab [8] = '{3'b010, 3'b110, 3'b000, 3'b001,
                              3'b011, 3'b111, 3'b100, 3'b101};

  multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .z(z), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ula_control(ula_control), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_instr(illegal_instr), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  function automatic int fn_idx(input logic [5:0] fn);
    int k = -1;
    for (int i = 0; i < 8; i++) if (fn_tab[i] == fn) k = i;
    return k;
  endfunction

  function automatic logic known_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  task automatic chk(input outs_t e, input string tag);
    outs_t o;
    o = {mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
         ula_control, reg_write, reg_dst, mem_to_reg, illegal_instr, bus_error};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step(input logic rdy, input outs_t e, input string tag);
    mem_ready = rdy;
    @(negedge clk);
    chk(e, tag);
    @(posedge clk);
    #1;
  endtask

  function automatic outs_t fetch_exp(input logic rdy);
    outs_t e = '0;
    e.mem_req = 1'b1;
    e.alu_src_b = 2'b01;
    e.ula_control = 3'b010;
    e.ir_write = rdy;
    e.pc_en = rdy;
    return e;
  endfunction

  // Runs one instruction from FETCH back to the next FETCH, fw/mw memory wait cycles.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic zz,
                          input int fw, input int mw);
    outs_t e;
    int k;
    logic legal;
    k = fn_idx(fn);
    legal = known_op(op) && (op != 6'b000000 || k >= 0);
    opcode = op;
    funct = fn;
    z = zz;
    for (int i = 0; i < fw; i++) step(1'b0, fetch_exp(1'b0), "fetch_wait");
    step(1'b1, fetch_exp(1'b1), "fetch");
    e = '0; e.alu_src_b = 2'b10; e.ula_control = 3'b010; e.illegal_instr = !legal;
    step(1'($urandom), e, "decode");
    if (!legal) return;
    e = '0;
    if (op == 6'b100011 || op == 6'b101011) begin
      e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.ula_control = 3'b010;
      step(1'($urandom), e, "memadr");
      e = '0; e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_write = (op == 6'b101011);
      for (int i = 0; i < mw; i++) step(1'b0, e, "mem_wait");
      step(1'b1, e, "mem_done");
      if (op == 6'b100011) begin
        e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        step(1'($urandom), e, "memwb");
      end
    end else if (op == 6'b000000) begin
      e.alu_src_a = 1'b1; e.ula_control = ulc_tab[k];
      step(1'($urandom), e, "exec");
      e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1;
      step(1'($urandom), e, "aluwb");
    end else if (op == 6'b000100) begin
      e.alu_src_a = 1'b1; e.ula_control = 3'b110; e.pc_src = 2'b01; e.pc_en = zz;
      step(1'($urandom), e, "branch");
    end else if (op == 6'b001000) begin
      e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.ula_control = 3'b010;
      step(1'($urandom), e, "addiex");
      e = '0; e.reg_write = 1'b1;
      step(1'($urandom), e, "addiwb");
    end else begin
      e.pc_src = 2'b10; e.pc_en = 1'b1;
      step(1'($urandom), e, "jump");
    end
  endtask

  initial begin
    outs_t e;
    logic [5:0] op, fn;
    int kind;
    rst = 1'b0; z = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
    #3 chk('0, "reset");
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b1, '0, "idle");
    do_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
    do_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
    do_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
    do_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
    do_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
    do_instr(6'b000000, 6'b111111, 1'b0, 0, 0);
    do_instr(6'b101011, 6'b000000, 1'b0, 1, 2);
    do_instr(6'b001000, 6'b000000, 1'b0, 0, 0);
    do_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 7);
      fn = fn_tab[$urandom_range(0, 7)];
      case (kind)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        6: do op = 6'($urandom); while (known_op(op));
        default: begin
          op = 6'b000000;
          do fn = 6'($urandom); while (fn_idx(fn) >= 0);
        end
      endcase
      do_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    // ready on the last allowed cycle succeeds, in FETCH and in the memory states
    do_instr(6'b100011, 6'b000000, 1'b0, 15, 15);
    do_instr(6'b101011, 6'b000000, 1'b0, 15, 15);
    opcode = 6'b000010;
    for (int i = 0; i < 16; i++) step(1'b0, fetch_exp(1'b0), "to_wait");
    e = '0; e.bus_error = 1'b1;
    for (int i = 0; i < 3; i++) step(1'($urandom), e, "halt");
    rst = 1'b0;
    #1 chk('0, "halt_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b0, '0, "idle2");
    opcode = 6'b100011;
    step(1'b1, fetch_exp(1'b1), "ab_fetch");
    e = '0; e.alu_src_b = 2'b10; e.ula_control = 3'b010;
    step(1'b0, e, "ab_decode");
    e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.ula_control = 3'b010;
    step(1'b0, e, "ab_memadr");
    mem_ready = 1'b1;
    @(negedge clk);
    e = '0; e.mem_req = 1'b1; e.i_or_d = 1'b1;
    chk(e, "ab_memrd");
    #2 rst = 1'b0;
    #1 chk('0, "abort_reset");
    @(posedge clk); #1;
    chk('0, "abort_hold");
    rst = 1'b1;
    step(1'b0, '0, "idle3");
    do_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control unit for the 16-bit MIPS-style datapath. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the ULA's 3-bit ULAControl together with all datapath mux selects and write strobes. It consumes the ULA Z flag for beq and handshakes with the unified memory through mem_req/mem_ready.

Parameters:
WAIT_MAX, 15, maximum number of cycles to wait for mem_ready before flagging bus_error
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
opcode  in  6  instruction register bits [31:26]
funct  in  6  instruction register bits [5:0]
z  in  1  ULA zero flag
mem_ready  in  1  memory has completed the current access
mem_req  out  1  memory access request
mem_write  out  1  store (valid while mem_req=1)
i_or_d  out  1  address select: 0 = PC, 1 = ULAOut
ir_write  out  1  load the instruction register
pc_en  out  1  PC load enable
pc_src  out  2  PC source: 00 = ULAResult, 01 = ULAOut, 10 = jump target
alu_src_a  out  1  SrcA select: 0 = PC, 1 = register A
alu_src_b  out  2  SrcB select: 00 = B, 01 = constant 1, 10 = sign-extended immediate
ula_control  out  3  drives the ULA ULAControl input
reg_write  out  1  register file write enable
reg_dst  out  1  destination register: 0 = rt, 1 = rd
mem_to_reg  out  1  writeback source: 0 = ULAOut, 1 = MDR
illegal_instr  out  1  one-cycle pulse on an undecodable instruction
bus_error  out  1  sticky flag; set on memory timeout

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-low. While rst=0: state=IDLE, wait_cnt=0, bus_error=0, and every output is 0.
- State register: states are IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
- Output timing: outputs are Moore decodes of the state, except pc_en and ir_write, which also depend on mem_ready or z.
- IDLE: all outputs 0. Goes to FETCH on the next clock.
- FETCH:
  - Outputs: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ula_control=010, pc_src=00.
  - When mem_ready=1: ir_write=1 and pc_en=1 for that cycle only, then go to DECODE.
  - Otherwise stay in FETCH and increment wait_cnt.
- DECODE: alu_src_a=0, alu_src_b=10, ula_control=010 to precompute the branch target. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - opcode 000000 with funct outside the legal set, or any other opcode -> FETCH with illegal_instr=1 for this cycle. No register or memory write occurs.
- MEMADR: alu_src_a=1, alu_src_b=10, ula_control=010. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, i_or_d=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Then FETCH.
- MEMWR: mem_req=1, mem_write=1, i_or_d=1. Waits for mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00. ula_control is mapped from funct:
  - 100000 -> 010 (add)
  - 100010 -> 110 (sub)
  - 100100 -> 000 (and)
  - 100101 -> 001 (or)
  - 100111 -> 011 (nor)
  - 101010 -> 111 (slt)
  - 000000 -> 100 (sll)
  - 000010 -> 101 (srl)
  - Then go to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, ula_control=110, pc_src=01, pc_en=z. Then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ula_control=010. Then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- JUMP: pc_src=10, pc_en=1. Then FETCH.
- Wait counter: wait_cnt clears on every state change. It increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0. When wait_cnt reaches WAIT_MAX with mem_ready still 0:
  - set bus_error=1 and go to HALT;
  - HALT drives all outputs 0 and is left only by reset.
- Simultaneous events: mem_ready=1 in the same cycle that wait_cnt reaches WAIT_MAX counts as success; no error is raised.
- Reset mid-instruction: abandons the instruction immediately. No partial strobe may be emitted after rst falls.
- Latencies with zero-wait memory:
  - lw 5 cycles; sw 4
  - R-type 4; addi 4
  - beq 3; j 3

Decomposition:
- Shared package: opcode constants, funct constants, ULAControl encodings (3'b000 to 3'b111), and the state encoding.
- One sub-module, ula_decoder: combinational funct/opcode to ula_control mapping plus a legal flag. The FSM instantiates it; DECODE uses the legal flag.

Test Plan:
- Reset, release rst, then fetch with mem_ready=1 -> IDLE, then FETCH; ir_write=1 and pc_en=1 in the same cycle; DECODE next cycle.
- R-type sub (opcode 000000, funct 100010) -> ula_control=110 in EXEC; reg_write=1 and reg_dst=1 in ALUWB; 4 cycles total.
- lw with mem_ready delayed 3 cycles in MEMRD -> MEMRD held for 4 cycles; MEMWB asserts mem_to_reg=1 and reg_write=1.
- beq with z=1, then beq with z=0 -> pc_en=1 with pc_src=01 in the first case; pc_en=0 in the second; both return to FETCH.
- Opcode 111111, and opcode 000000 with funct 111111 -> illegal_instr pulses one cycle in DECODE; no reg_write or mem_write; next state FETCH.
- mem_ready held at 0 in FETCH -> bus_error=1 after 15 cycles; state HALT with all outputs 0; asserting rst clears it back to IDLE.
